ps2_host_tx: RTL

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to a keyboard/mouse.

---
 rtl/ps2_host_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter on shared open-drain clock/data pins; holds off the receiver while busy.
// Define PS2_TX_ACK_CHECK_EN to report a missing device ACK as an error instead of completing normally.
module ps2_host_tx #(
  parameter int FILTER_LEN     = 16,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        ps2clk,
  inout  wire        ps2data,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       rx_hold,
  output logic       tx_done_stb,
  output logic       tx_error_stb
);

  localparam int CNT_A   = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int CNT_MAX = (CNT_A > TIMEOUT_CYCLES) ? CNT_A : TIMEOUT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, DONE} state_t;

  state_t                state_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  level_q, level_d, clk_fall;
  logic [1:0]            data_sync_q;
  logic [9:0]            shift_q;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            bitcnt_q;
  logic                  clk_oe_q, data_oe_q, busy_q, done_q, err_q;

  // Level only moves after FILTER_LEN identical samples, so short glitches never make an edge.
  always_comb begin
    filt_d  = {filt_q[FILTER_LEN-2:0], ps2clk};
    level_d = level_q;
    if (&filt_d)
      level_d = 1'b1;
    else if (~|filt_d)
      level_d = 1'b0;
  end

  assign clk_fall = level_q & ~level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q      <= '1;
      level_q     <= 1'b1;
      data_sync_q <= 2'b11;
    end else begin
      filt_q      <= filt_d;
      level_q     <= level_d;
      data_sync_q <= {data_sync_q[0], ps2data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '1;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tx_start) begin
            shift_q  <= {1'b1, ~^tx_data, tx_data};
            busy_q   <= 1'b1;
            clk_oe_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
            data_oe_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= START;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        START: begin
          if (cnt_q == CW'(START_CYCLES - 1)) begin
            clk_oe_q <= 1'b0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            state_q  <= SEND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SEND, ACK, DONE: begin
          // Timeout wins over any clock edge arriving in the same cycle.
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            case (state_q)
              SEND: begin
                if (clk_fall) begin
                  data_oe_q <= ~shift_q[0];
                  shift_q   <= {1'b1, shift_q[9:1]};
                  bitcnt_q  <= bitcnt_q + 1'b1;
                  if (bitcnt_q == 4'd9)
                    state_q <= ACK;
                end
              end
              ACK: begin
                if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                  if (data_sync_q[1]) begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    err_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                  end else begin
                    state_q <= DONE;
                  end
`else
                  state_q <= DONE;
`endif
                end
              end
              DONE: begin
                if (level_q && data_sync_q[1]) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end
              end
              default: ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2clk       = clk_oe_q  ? 1'b0 : 1'bz;
  assign ps2data      = data_oe_q ? 1'b0 : 1'bz;
  assign tx_busy      = busy_q;
  assign rx_hold      = busy_q;
  assign tx_done_stb  = done_q;
  assign tx_error_stb = err_q;

endmodule
